// File: rtl/mem_bus_pkg.sv
// Shared definitions for the PicoRV32-style native memory bus:
// arbiter state encoding, request bundle and default error read data.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Plain-vector copies of the state encoding for registers kept as logic.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // One native-bus request as presented by a master.
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // Read data handed back when the slave never answers.
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Native memory bus bundle. "master" drives the request and receives the
// completion; "slave" is the opposite side. err is a timeout flag raised by
// the arbiter towards its masters; a real memory slave leaves it at 0.
interface mem_arbiter2_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata, err
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata, err
    );
endinterface

// File: rtl/mem_arbiter2_rr_arb2.sv
// Two-way round-robin pick. With a single requester it wins; with both
// requesting, the one that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // Combinational winner selection from the request pair and last grant.
    always_comb begin
        gnt_valid_o = |req_i;
        if (&req_i) begin
            gnt_idx_o = ~last_i;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master arbiter in front of one native-bus memory slave. Requests are
// serialised round-robin, the slave request is registered, and a watchdog
// completes an unanswered access with err=1 and ERR_RDATA.
module mem_arbiter2
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic           clk,
    input  logic           resetn,
    mem_arbiter2_if.slave  m0,
    mem_arbiter2_if.slave  m1,
    mem_arbiter2_if.master s,
    output logic           grant_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic          s_valid_q, s_valid_d;
    mem_req_t      req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_q, grant_d;

    // Completion produced this cycle, routed to the granted master's registers.
    logic          done_d;
    logic [31:0]   rsp_rdata_d;
    logic          rsp_err_d;

    logic          ready_q [2];
    logic [31:0]   rdata_q [2];
    logic          err_q   [2];

    mem_req_t      m0_req_w, m1_req_w;
    logic          gnt_valid_w, gnt_idx_w;

    assign m0_req_w = '{instr: m0.instr, addr: m0.addr, wdata: m0.wdata, wstrb: m0.wstrb};
    assign m1_req_w = '{instr: m1.instr, addr: m1.addr, wdata: m1.wdata, wstrb: m1.wstrb};

    rr_arb2 u_rr_arb2 (
        .req_i       ({m1.valid, m0.valid}),
        .last_i      (grant_q),
        .gnt_valid_o (gnt_valid_w),
        .gnt_idx_o   (gnt_idx_w)
    );

    // Next-state logic: grant in IDLE, wait for slave or timeout in BUSY,
    // one response cycle in RESP. s.ready only matters in BUSY.
    always_comb begin
        state_d     = state_q;
        s_valid_d   = s_valid_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        done_d      = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_w) begin
                    grant_d   = gnt_idx_w;
                    req_d     = gnt_idx_w ? m1_req_w : m0_req_w;
                    s_valid_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s.ready) begin
                    rsp_rdata_d = (req_q.wstrb == 4'h0) ? s.rdata : 32'h0;
                    done_d      = 1'b1;
                    s_valid_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_rdata_d = ERR_RDATA;
                    rsp_err_d   = 1'b1;
                    done_d      = 1'b1;
                    s_valid_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state, registered slave request and watchdog counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            s_valid_q <= 1'b0;
            req_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_valid_q <= s_valid_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
        end
    end

    // Per-master completion registers: ready pulses for the RESP cycle,
    // rdata/err hold until that master's next completion.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        // Load the response when the granted master's transaction finishes.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                ready_q[gi] <= 1'b0;
                rdata_q[gi] <= '0;
                err_q[gi]   <= 1'b0;
            end else begin
                ready_q[gi] <= done_d && (grant_q == 1'(gi));
                if (done_d && (grant_q == 1'(gi))) begin
                    rdata_q[gi] <= rsp_rdata_d;
                    err_q[gi]   <= rsp_err_d;
                end
            end
        end
    end

    assign s.valid  = s_valid_q;
    assign s.instr  = req_q.instr;
    assign s.addr   = req_q.addr;
    assign s.wdata  = req_q.wdata;
    assign s.wstrb  = req_q.wstrb;

    assign m0.ready = ready_q[0];
    assign m0.rdata = rdata_q[0];
    assign m0.err   = err_q[0];
    assign m1.ready = ready_q[1];
    assign m1.rdata = rdata_q[1];
    assign m1.err   = err_q[1];

    assign grant_o  = grant_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: single read, contention, continuous
// alternation, watchdog timeout with late ready, and mid-transaction reset.
module tb_mem_arbiter2;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic grant;

    always #5 clk = ~clk;

    mem_arbiter2_if m0_if ();
    mem_arbiter2_if m1_if ();
    mem_arbiter2_if s_if ();

    mem_arbiter2 #(
        .TIMEOUT   (TO),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant)
    );

    int n_chk = 0;
    int n_pass = 0;

    int step_no;
    int sv_cycles;
    int r_cnt [2];
    int ready_step [2];
    int last_ready_step;
    logic [31:0] last_rdata [2];
    logic last_err [2];
    logic sv_prev;
    bit slave_en;
    int slave_wait;
    int wcnt;
    logic [31:0] slave_rdata;
    bit repeat_req [2];

    logic gq [$];
    logic instr_q [$];
    logic [31:0] addr_q [$];
    logic [31:0] wdata_q [$];
    logic [3:0] wstrb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clear_stats();
        step_no = 0;
        sv_cycles = 0;
        last_ready_step = 0;
        sv_prev = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 2; i++) begin
            r_cnt[i] = 0;
            ready_step[i] = 0;
            last_rdata[i] = '0;
            last_err[i] = 1'b0;
            repeat_req[i] = 1'b0;
        end
        gq.delete();
        instr_q.delete();
        addr_q.delete();
        wdata_q.delete();
        wstrb_q.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;
        s_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_stats();
    endtask

    // One clock: observe outputs just after the edge, then update the
    // slave model and the masters' valid lines.
    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        if (s_if.valid) sv_cycles++;
        if (s_if.valid && !sv_prev) begin
            gq.push_back(grant);
            instr_q.push_back(s_if.instr);
            addr_q.push_back(s_if.addr);
            wdata_q.push_back(s_if.wdata);
            wstrb_q.push_back(s_if.wstrb);
        end
        sv_prev = s_if.valid;
        if (m0_if.ready) begin
            r_cnt[0]++;
            if (ready_step[0] == 0) ready_step[0] = step_no;
            last_ready_step = step_no;
            last_rdata[0] = m0_if.rdata;
            last_err[0] = m0_if.err;
            $display("step %0d: m0 done rdata=0x%08h err=%0b", step_no, m0_if.rdata, m0_if.err);
            if (!repeat_req[0]) m0_if.valid = 1'b0;
        end
        if (m1_if.ready) begin
            r_cnt[1]++;
            if (ready_step[1] == 0) ready_step[1] = step_no;
            last_ready_step = step_no;
            last_rdata[1] = m1_if.rdata;
            last_err[1] = m1_if.err;
            $display("step %0d: m1 done rdata=0x%08h err=%0b", step_no, m1_if.rdata, m1_if.err);
            if (!repeat_req[1]) m1_if.valid = 1'b0;
        end
        if (slave_en && s_if.valid) begin
            if (wcnt == slave_wait) begin
                s_if.ready = 1'b1;
                s_if.rdata = slave_rdata;
            end else begin
                s_if.ready = 1'b0;
                wcnt++;
            end
        end else begin
            s_if.ready = 1'b0;
            wcnt = 0;
        end
    endtask

    initial begin
        int alt_err;
        m0_if.valid = 1'b0; m0_if.instr = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
        m1_if.valid = 1'b0; m1_if.instr = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
        s_if.ready = 1'b0; s_if.rdata = '0; s_if.err = 1'b0;
        slave_en = 1'b1; slave_wait = 0; slave_rdata = '0;

        // Reset values, then a lone M0 read with two slave wait cycles.
        do_reset();
        check("rst_s_valid", s_if.valid, 0);
        check("rst_s_addr", s_if.addr, 0);
        check("rst_s_wdata", s_if.wdata, 0);
        check("rst_s_wstrb", s_if.wstrb, 0);
        check("rst_grant", grant, 1);
        check("rst_m0_ready", m0_if.ready, 0);
        check("rst_m1_ready", m1_if.ready, 0);
        check("rst_m0_rdata", m0_if.rdata, 0);
        check("rst_m0_err", m0_if.err, 0);
        m0_if.instr = 1'b0; m0_if.addr = 32'h10; m0_if.wstrb = 4'h0; m0_if.valid = 1'b1;
        slave_en = 1'b1; slave_wait = 2; slave_rdata = 32'h1234_5678;
        repeat (8) step();
        check("t1_s_valid_cycles", sv_cycles, 3);
        check("t1_m0_ready_count", r_cnt[0], 1);
        check("t1_m1_ready_count", r_cnt[1], 0);
        check("t1_ready_step", ready_step[0], 4);
        check("t1_rdata", last_rdata[0], 32'h1234_5678);
        check("t1_err", last_err[0], 0);
        check("t1_rdata_hold", m0_if.rdata, 32'h1234_5678);
        check("t1_grants", gq.size(), 1);
        if (gq.size() >= 1) check("t1_s_addr", addr_q[0], 32'h10);

        // Simultaneous M0 fetch and M1 write: M0 first, M1 one idle cycle later.
        do_reset();
        m0_if.instr = 1'b1; m0_if.addr = 32'h0; m0_if.wdata = 32'h0; m0_if.wstrb = 4'h0; m0_if.valid = 1'b1;
        m1_if.instr = 1'b0; m1_if.addr = 32'h100; m1_if.wdata = 32'hA5A5_A5A5; m1_if.wstrb = 4'hF; m1_if.valid = 1'b1;
        slave_en = 1'b1; slave_wait = 0; slave_rdata = 32'h0000_0013;
        repeat (8) step();
        check("t2_grants", gq.size(), 2);
        if (gq.size() >= 2) begin
            check("t2_first_grant", gq[0], 0);
            check("t2_first_instr", instr_q[0], 1);
            check("t2_second_grant", gq[1], 1);
            check("t2_second_wstrb", wstrb_q[1], 4'hF);
            check("t2_second_wdata", wdata_q[1], 32'hA5A5_A5A5);
            check("t2_second_addr", addr_q[1], 32'h100);
        end
        check("t2_m0_ready_step", ready_step[0], 2);
        check("t2_m1_ready_step", ready_step[1], 5);
        check("t2_m0_rdata", last_rdata[0], 32'h0000_0013);
        check("t2_m1_write_rdata", last_rdata[1], 32'h0);

        // Both masters requesting back to back: strict alternation, 3 cycles each.
        do_reset();
        m0_if.instr = 1'b0; m0_if.addr = 32'h200; m0_if.wstrb = 4'h0;
        m1_if.instr = 1'b0; m1_if.addr = 32'h300; m1_if.wstrb = 4'h0;
        repeat_req[0] = 1'b1; repeat_req[1] = 1'b1;
        m0_if.valid = 1'b1; m1_if.valid = 1'b1;
        slave_en = 1'b1; slave_wait = 0; slave_rdata = 32'h0000_0042;
        repeat (60) step();
        check("t3_grants", gq.size(), 20);
        alt_err = 0;
        for (int i = 0; i < gq.size(); i++) if (gq[i] !== 1'(i % 2)) alt_err++;
        check("t3_alternation_errors", alt_err, 0);
        check("t3_s_valid_cycles", sv_cycles, 20);
        check("t3_m0_count", r_cnt[0], 10);
        check("t3_m1_count", r_cnt[1], 10);
        check("t3_last_ready_step", last_ready_step, 59);

        // Silent slave: watchdog after TO cycles, late ready is ignored.
        do_reset();
        m1_if.instr = 1'b0; m1_if.addr = 32'h20; m1_if.wstrb = 4'h0; m1_if.valid = 1'b1;
        slave_en = 1'b0;
        repeat (11) step();
        s_if.ready = 1'b1;
        s_if.rdata = 32'h5555_5555;
        repeat (4) step();
        check("t4_s_valid_cycles", sv_cycles, TO);
        check("t4_m1_count", r_cnt[1], 1);
        check("t4_m0_count", r_cnt[0], 0);
        check("t4_ready_step", ready_step[1], TO + 1);
        check("t4_rdata", last_rdata[1], 32'hDEAD_BEEF);
        check("t4_err", last_err[1], 1);
        check("t4_err_hold", m1_if.err, 1);
        check("t4_grants", gq.size(), 1);

        // Reset while BUSY drops the request; a fresh M1 read then completes.
        do_reset();
        m0_if.instr = 1'b0; m0_if.addr = 32'h40; m0_if.wstrb = 4'h0; m0_if.valid = 1'b1;
        slave_en = 1'b0;
        repeat (3) step();
        check("t5_busy_before_reset", s_if.valid, 1);
        resetn = 1'b0;
        m0_if.valid = 1'b0;
        step();
        resetn = 1'b1;
        check("t5_rst_s_valid", s_if.valid, 0);
        check("t5_rst_s_addr", s_if.addr, 0);
        check("t5_rst_grant", grant, 1);
        check("t5_rst_m0_ready", m0_if.ready, 0);
        m1_if.instr = 1'b0; m1_if.addr = 32'h80; m1_if.wstrb = 4'h0; m1_if.valid = 1'b1;
        slave_en = 1'b1; slave_wait = 1; slave_rdata = 32'hCAFE_F00D;
        repeat (8) step();
        check("t5_m0_count", r_cnt[0], 0);
        check("t5_m1_count", r_cnt[1], 1);
        check("t5_m1_rdata", last_rdata[1], 32'hCAFE_F00D);
        check("t5_m1_err", last_err[1], 0);
        check("t5_grants", gq.size(), 2);
        if (gq.size() >= 2) check("t5_fresh_grant", gq[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master arbiter that shares one single-port memory slave using the PicoRV32 native memory protocol (valid/ready, wstrb, instr flag). Master 0 is the PicoRV32 core. Master 1 is a secondary requester, such as a debug/loader port or DMA. The block serialises their requests with round-robin fairness and registers the slave-side request. A per-transaction timeout watchdog completes the access with an error if the slave never answers, so a missing slave cannot hang the core.

## Interface
- TIMEOUT, 64 — slave-wait cycles before abort; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF — rdata returned on a timed-out read.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- mN_valid  in  1  request from master N (N=0,1); held until mN_ready.
- mN_instr  in  1  instruction-fetch flag, forwarded unchanged.
- mN_addr  in  32  byte address.
- mN_wdata  in  32  write data.
- mN_wstrb  in  4  byte strobes; 0 means read.
- mN_ready  out  1  one-cycle completion pulse.
- mN_rdata  out  32  read data, valid while mN_ready=1.
- mN_err  out  1  timeout flag, valid while mN_ready=1.
- s_valid  out  1  request to slave.
- s_instr, s_addr, s_wdata, s_wstrb  out  1/32/32/4  registered copy of the granted master's request.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data, sampled when s_ready=1.
- grant  out  1  index of the current or last granted master.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant that master.
  - Both valid: grant the master that is not `grant`; `grant` resets to 1, so master 0 wins the first contention.
  - On grant: latch instr/addr/wdata/wstrb into the s_* registers, set s_valid=1, clear the timeout counter, go to BUSY.
- BUSY:
  - s_valid held at 1 and s_* stable.
  - s_ready=1: latch s_rdata (reads) or 0 (writes) into the return register, err=0, s_valid←0, go to RESP.
  - Else, when the counter reaches TIMEOUT-1: return ERR_RDATA, err=1, s_valid←0, go to RESP.
  - Else increment the counter.
- RESP:
  - m{grant}_ready=1 for exactly this cycle, with rdata and err.
  - The other master's ready stays 0.
  - Always go to IDLE.
- Masters drop valid at the edge where they sample ready=1, so no stale re-grant occurs in the following IDLE.
- s_ready while s_valid=0 (late ready after an abort, or in IDLE/RESP) is ignored.
- A write that times out is reported with err=1. Whether the slave committed it is undefined.
- Reset values:
  - state=IDLE, s_valid=0, s_instr=0, s_addr=0, s_wdata=0, s_wstrb=0.
  - m0_ready=m1_ready=0, mN_rdata=0, mN_err=0, grant=1, counter=0.
- Reset asserted mid-transaction: the next edge forces the reset values. The in-flight request is dropped and no ready is issued.

## Timing
- Master valid sampled at edge N gives s_valid=1 from N+1.
- s_ready sampled at edge K gives mN_ready=1 during cycle K+1 only.
- Minimum transaction: valid at edge N, slave answers in its first cycle (K=N+1), mN_ready during cycle N+2. That is 3 cycles valid→ready, with 1 idle cycle between back-to-back grants.
- Timeout: s_valid is high for exactly TIMEOUT cycles, then RESP.
- All outputs are registered; there is no combinational path from any input to any output.
- mN_rdata and mN_err hold their value after RESP until the next completion for that master.

## Structure
- Shared package (mem_bus_pkg): state enum {IDLE,BUSY,RESP}, the native request struct (instr, addr, wdata, wstrb), and the ERR_RDATA default constant.
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req[1:0], last) to (gnt_valid, gnt_idx), reusable by future N-way arbiters.
- Counter width: $clog2(TIMEOUT+1).

## Test plan
- M0 read 0x0000_0010 alone, slave answers after 2 wait cycles with 0x1234_5678 → s_valid for 3 cycles; m0_ready pulses once with rdata=0x1234_5678, err=0; m1_ready stays 0.
- M0 fetch and M1 write (addr 0x100, wdata 0xA5A5_A5A5, wstrb 0xF) asserted in the same cycle after reset → M0 served first with s_instr=1; M1 served next with s_wstrb=0xF and s_wdata=0xA5A5_A5A5.
- Both masters continuously requesting for 20 transactions, slave zero-wait → grants strictly alternate 0,1,0,1…; each transaction takes 3 cycles.
- TIMEOUT=8 with s_ready tied 0 → s_valid high exactly 8 cycles; master gets ready with rdata=0xDEAD_BEEF, err=1; a late s_ready 2 cycles later causes no extra ready.
- resetn low for 1 cycle while in BUSY → all outputs return to reset values next edge; no ready pulse; a fresh M1 request afterwards completes normally.
- PicoRV32 core on M0 running the fetch program, M1 idle → fetch addresses 0x00, 0x04, … match the core-direct run; no trap.
